run_control: RTL and testbench
==============================

Name: run_control

Overview:
- Synthesizable board-level run controller for the CPU; the next generation of the button/switch reset-and-start sequencing used around the full-integration top.
- Debounces the raw reset (w_button) and start/step (s_button) buttons.
- Generates a stretched CPU reset, then gates the CPU clock enable in one of three switch-selected modes: free run, single step, or N-cycle burst.
- Latches a CPU halt indication and keeps a saturating executed-cycle count for LED/LCD display.

Parameters:
- RST_CYCLES, 4: number of cycles cpu_reset stays high after reset or a w press.
- DEBOUNCE_CYCLES, 8: consecutive stable synchronized samples required to change a debounced level.
- BURST_W, 4: width of burst_len; burst_len==0 means 2^BURST_W cycles.
- CYC_W, 32: width of cycle_count.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- w_button  in  1  raw button; a press requests CPU reset.
- s_button  in  1  raw button; a press starts, steps or pauses the CPU.
- mode  in  2  switch mode: 0 RUN, 1 STEP, 2 BURST, 3 reserved.
- burst_len  in  BURST_W  burst length from switches.
- halt_in  in  1  CPU halt flag.
- cpu_reset  out  1  reset to CPU core.
- cpu_en  out  1  CPU clock enable.
- halted  out  1  CPU halt latched.
- cycle_count  out  CYC_W  cycles with cpu_en=1, saturating.
- state  out  3  current state encoding, for LEDs.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state: RESETTING (encoding 0). cpu_reset=1, cpu_en=0, halted=0, cycle_count=0. Sync flops, debounced levels and debounce counters all 0. Reset asserted mid-operation aborts any mode immediately.
- Input path: each button goes through 2 synchronizer flops.
  - The debounce counter increments while the synced value differs from the debounced level; it clears when they agree.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES.
  - A press is a one-cycle pulse on the debounced 0->1 edge. Release produces no pulse.
  - A glitch shorter than DEBOUNCE_CYCLES produces no press.
- Outputs are Moore decodes of the registered state.
  - cpu_en=1 only in RUN, STEP and BURST.
  - cpu_reset=1 only in RESETTING.
  - halted=1 only in HALTED.
- State encodings: RESETTING=0, IDLE=1, RUN=2, STEP=3, BURST=4, HALTED=5.
- Per-cycle priority: reset > w press > halt_in (in an enabled state) > s press > counter expiry.
- RESETTING:
  - Entered from any state on a w press; the entry clears cycle_count and the reset counter.
  - Stays exactly RST_CYCLES cycles, then goes to IDLE.
  - A w press during RESETTING restarts the count.
- IDLE: on an s press, samples mode and burst_len.
  - mode 0 -> RUN.
  - mode 1 -> STEP.
  - mode 2 -> BURST, loading the burst counter with burst_len (0 loads 2^BURST_W).
  - mode 3 -> remains in IDLE.
  - mode and burst_len are ignored at all other times.
- RUN: cpu_en=1 every cycle; an s press goes to IDLE (pause).
- STEP: exactly one cycle with cpu_en=1, then IDLE. An s press in this cycle is ignored.
- BURST:
  - cpu_en=1 for exactly the loaded count; the counter decrements each cycle; IDLE follows the last enabled cycle.
  - s presses are ignored.
- halt_in high in any enabled state -> HALTED next cycle. halt_in is ignored in other states.
- HALTED: only a w press exits (to RESETTING). halted stays 1 until then.
- cycle_count:
  - Increments on every cycle where cpu_en=1.
  - Saturates at all-ones; no wrap.
  - Holds through IDLE and HALTED.
  - Cleared by reset or entry to RESETTING.
- Simultaneous w and s presses: w wins, and the s press is discarded.

Test Plan:
- Use DEBOUNCE_CYCLES=4, RST_CYCLES=4, BURST_W=4, CYC_W=8.
- Reset pulse, then idle inputs -> cpu_reset=1 for exactly 4 cycles after reset drops; state=1; cpu_en=0; cycle_count=0.
- mode=0, hold s_button 10 cycles, run 20 cycles, press s again -> cpu_en high until the second press takes effect; then state=1 and cycle_count equals the number of enabled cycles.
- mode=1, three separate s presses -> exactly 3 single-cycle cpu_en pulses; cycle_count=3.
- mode=2, burst_len=5, then burst_len=0 -> 5 enabled cycles, then 16 enabled cycles; cycle_count=21. An s press mid-burst has no effect.
- RUN with halt_in raised for 1 cycle -> state=5 and halted=1 the next cycle; later s presses ignored; a w press -> cpu_reset for 4 cycles, then IDLE with cycle_count=0.
- A 2-cycle s glitch -> no state change. CYC_W=8 run for 300 cycles -> cycle_count=255.

Source files
------------

// File: rtl/run_control.sv
`timescale 1ns/1ps
// Board-level CPU run controller: debounces the reset/step buttons, stretches CPU
// reset, and gates the CPU clock enable in run, single-step or burst mode.
module run_control #(
  parameter int unsigned RST_CYCLES      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned BURST_W         = 4,
  parameter int unsigned CYC_W           = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_button,
  input  logic               s_button,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_in,
  output logic               cpu_reset,
  output logic               cpu_en,
  output logic               halted,
  output logic [CYC_W-1:0]   cycle_count,
  output logic [2:0]         state
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RESETTING = 3'd0,
    S_IDLE      = 3'd1,
    S_RUN       = 3'd2,
    S_STEP      = 3'd3,
    S_BURST     = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  // Button lanes: bit 0 is w_button, bit 1 is s_button.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync0;
  logic [1:0]      r_sync1;
  logic [1:0]      r_lvl;
  logic [1:0]      r_lvl_q;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      w_press;

  state_t             r_state;
  logic [RST_W-1:0]   r_rst_cnt;
  logic [BURST_W:0]   r_burst_cnt;
  logic [CYC_W-1:0]   r_cyc;
  logic               w_enabled;

  assign w_raw   = {s_button, w_button};
  assign w_press = r_lvl & ~r_lvl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0  <= '0;
      r_sync1  <= '0;
      r_lvl    <= '0;
      r_lvl_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      r_lvl_q <= r_lvl;
      // Level flips once the synced input has disagreed for DEBOUNCE_CYCLES samples.
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_lvl[i]    <= r_sync1[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_enabled = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RESETTING;
      r_rst_cnt   <= '0;
      r_burst_cnt <= '0;
      r_cyc       <= '0;
    end else begin
      if (w_enabled && !(&r_cyc)) begin
        r_cyc <= r_cyc + 1'b1;
      end
      // A w press overrides everything, including the count increment above.
      if (w_press[0]) begin
        r_state   <= S_RESETTING;
        r_rst_cnt <= '0;
        r_cyc     <= '0;
      end else if (w_enabled && halt_in) begin
        r_state <= S_HALTED;
      end else begin
        case (r_state)
          S_RESETTING: begin
            if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
              r_state <= S_IDLE;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          S_IDLE: begin
            if (w_press[1]) begin
              case (mode)
                2'd0: r_state <= S_RUN;
                2'd1: r_state <= S_STEP;
                2'd2: begin
                  r_state     <= S_BURST;
                  r_burst_cnt <= (burst_len == '0) ? {1'b1, {BURST_W{1'b0}}}
                                                   : {1'b0, burst_len};
                end
                default: r_state <= S_IDLE;
              endcase
            end
          end
          S_RUN: begin
            if (w_press[1]) begin
              r_state <= S_IDLE;
            end
          end
          S_STEP: r_state <= S_IDLE;
          S_BURST: begin
            if (r_burst_cnt <= (BURST_W + 1)'(1)) begin
              r_state <= S_IDLE;
            end else begin
              r_burst_cnt <= r_burst_cnt - 1'b1;
            end
          end
          S_HALTED: r_state <= S_HALTED;
          default:  r_state <= S_RESETTING;
        endcase
      end
    end
  end

  assign cpu_reset   = (r_state == S_RESETTING);
  assign cpu_en      = w_enabled;
  assign halted      = (r_state == S_HALTED);
  assign cycle_count = r_cyc;
  assign state       = r_state;

endmodule

// File: tb/tb_run_control.sv
`timescale 1ns/1ps
// Directed bench for run_control: reset stretch, run/step/burst modes, halt latch,
// debounce glitch rejection, w/s collision and cycle-count saturation.
module tb_run_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       w_button;
  logic       s_button;
  logic [1:0] mode;
  logic [3:0] burst_len;
  logic       halt_in;
  logic       cpu_reset;
  logic       cpu_en;
  logic       halted;
  logic [7:0] cycle_count;
  logic [2:0] state;

  int n_chk = 0;
  int n_bad = 0;
  int en_seen = 0;
  int e0;
  int hi;

  always #5 clk = ~clk;

  run_control #(
    .RST_CYCLES(4),
    .DEBOUNCE_CYCLES(4),
    .BURST_W(4),
    .CYC_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .w_button(w_button),
    .s_button(s_button),
    .mode(mode),
    .burst_len(burst_len),
    .halt_in(halt_in),
    .cpu_reset(cpu_reset),
    .cpu_en(cpu_en),
    .halted(halted),
    .cycle_count(cycle_count),
    .state(state)
  );

  always @(negedge clk) begin
    if (cpu_en === 1'b1) en_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
    int n = 0;
    while (state !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {29'd0, state}, {29'd0, exp});
  endtask

  task automatic press_s(input int hold, input int gap);
    s_button = 1'b1;
    tick(hold);
    s_button = 1'b0;
    tick(gap);
  endtask

  task automatic clear_count();
    w_button = 1'b1;
    tick(10);
    w_button = 1'b0;
    wait_state(3'd1, 40, "clr_idle");
    tick(10);
    chk("clr_cnt", {24'd0, cycle_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; w_button = 1'b0; s_button = 1'b0;
    mode = 2'd0; burst_len = 4'd0; halt_in = 1'b0;
    tick(3);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_count", {24'd0, cycle_count}, 32'd0);

    // cpu_reset stays up for exactly 4 cycles after reset drops
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_reset === 1'b1) hi++;
      tick();
    end
    chk("rst_len", hi, 32'd4);
    chk("rst_idle", {29'd0, state}, 32'd1);
    chk("rst_idle_en", {31'd0, cpu_en}, 32'd0);

    // RUN: presses 30 cycles apart -> exactly 30 enabled cycles
    mode = 2'd0;
    e0 = en_seen;
    s_button = 1'b1; tick(10); s_button = 1'b0; tick(20);
    chk("run_state", {29'd0, state}, 32'd2);
    chk("run_en", {31'd0, cpu_en}, 32'd1);
    s_button = 1'b1; tick(10); s_button = 1'b0;
    wait_state(3'd1, 40, "run_pause");
    tick(10);
    chk("run_count", {24'd0, cycle_count}, 32'd30);
    chk("run_en_cycles", en_seen - e0, 32'd30);

    // STEP: three presses -> three single enable cycles
    clear_count();
    mode = 2'd1;
    e0 = en_seen;
    for (int i = 0; i < 3; i++) press_s(10, 12);
    chk("step_state", {29'd0, state}, 32'd1);
    chk("step_en_cycles", en_seen - e0, 32'd3);
    chk("step_count", {24'd0, cycle_count}, 32'd3);

    // BURST: 5 then 16 (burst_len=0), mid-burst press and switch changes ignored
    clear_count();
    mode = 2'd2; burst_len = 4'd5;
    e0 = en_seen;
    press_s(10, 25);
    chk("burst5_en", en_seen - e0, 32'd5);
    chk("burst5_count", {24'd0, cycle_count}, 32'd5);
    chk("burst5_idle", {29'd0, state}, 32'd1);
    burst_len = 4'd0;
    e0 = en_seen;
    press_s(6, 7);
    s_button = 1'b1; burst_len = 4'd3; mode = 2'd0;
    tick(6);
    s_button = 1'b0;
    chk("burst_mid", {29'd0, state}, 32'd4);
    tick(30);
    chk("burst16_idle", {29'd0, state}, 32'd1);
    chk("burst16_en", en_seen - e0, 32'd16);
    chk("burst_count", {24'd0, cycle_count}, 32'd21);

    // HALT: one-cycle halt_in in RUN, latched until a w press
    mode = 2'd0;
    s_button = 1'b1;
    wait_state(3'd2, 20, "halt_run");
    s_button = 1'b0;
    tick(5);
    halt_in = 1'b1; tick(); halt_in = 1'b0;
    chk("halt_state", {29'd0, state}, 32'd5);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_en", {31'd0, cpu_en}, 32'd0);
    chk("halt_count", {24'd0, cycle_count}, 32'd27);
    press_s(10, 12);
    chk("halt_s_ign", {29'd0, state}, 32'd5);
    chk("halt_hold_cnt", {24'd0, cycle_count}, 32'd27);
    w_button = 1'b1;
    wait_state(3'd0, 20, "halt_wrst");
    chk("wrst_count", {24'd0, cycle_count}, 32'd0);
    hi = 0;
    while (cpu_reset === 1'b1 && hi < 10) begin
      hi++;
      tick();
    end
    w_button = 1'b0;
    chk("wrst_len", hi, 32'd4);
    chk("wrst_idle", {29'd0, state}, 32'd1);
    tick(10);

    // 2-cycle glitch on s is rejected
    e0 = en_seen;
    s_button = 1'b1; tick(2); s_button = 1'b0; tick(15);
    chk("glitch_state", {29'd0, state}, 32'd1);
    chk("glitch_en", en_seen - e0, 32'd0);

    // Simultaneous w and s presses: w wins, s discarded
    e0 = en_seen;
    w_button = 1'b1; s_button = 1'b1; tick(10);
    w_button = 1'b0; s_button = 1'b0; tick(15);
    chk("ws_state", {29'd0, state}, 32'd1);
    chk("ws_en", en_seen - e0, 32'd0);

    // Saturation after 300 cycles of RUN, then reset mid-run
    press_s(10, 300);
    chk("sat_state", {29'd0, state}, 32'd2);
    chk("sat_count", {24'd0, cycle_count}, 32'd255);
    reset = 1'b1; tick(); 
    chk("midrst_state", {29'd0, state}, 32'd0);
    chk("midrst_count", {24'd0, cycle_count}, 32'd0);
    chk("midrst_en", {31'd0, cpu_en}, 32'd0);
    chk("midrst_cpurst", {31'd0, cpu_reset}, 32'd1);
    reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
